quote_order_gen: RTL

- Sits directly downstream of the quote pricing stage.
- Turns each (buy, ask) quote into order messages on a valid/ready stream toward the order-entry/packetiser stage.
- Sends an order only for a side with no live order, or whose price moved by at least a threshold.
- Rate-limits quote updates and drops crossed quotes.
- Input side has no backpressure: the latest quote always wins.

---
 rtl/quote_order_gen.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/quote_order_gen.sv
// quote_order_gen: turns (bid, ask) quotes into NEW/REPLACE order messages on a
// valid/ready stream. Only sides with no live order, or whose price moved by at
// least THRESH, are sent. After an update that sent orders, MIN_GAP idle cycles
// pass before the next one. Crossed quotes are dropped and counted. The input
// has no backpressure, so a newer quote always overwrites an unconsumed one.
module quote_order_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int QTY_WIDTH  = 16,
  parameter int ORDER_QTY  = 100,
  parameter int THRESH     = 4,
  parameter int MIN_GAP    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_buy_price,
  input  logic [DATA_WIDTH-1:0] i_ask_price,
  input  logic                  i_data_valid,
  output logic                  o_order_valid,
  input  logic                  i_order_ready,
  output logic                  o_order_side,
  output logic [1:0]            o_order_type,
  output logic [DATA_WIDTH-1:0] o_order_price,
  output logic [QTY_WIDTH-1:0]  o_order_qty,
  output logic                  o_busy,
  output logic [15:0]           o_drop_count
);

  localparam int GAP_W = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
  localparam logic [1:0] T_NEW     = 2'd0;
  localparam logic [1:0] T_REPLACE = 2'd1;

  typedef enum logic [1:0] {IDLE, SEND_BID, SEND_ASK} state_t;

  state_t                state;
  logic                  pend_valid;
  logic [DATA_WIDTH-1:0] pend_bid, pend_ask;
  logic [DATA_WIDTH-1:0] work_bid, work_ask;
  logic [DATA_WIDTH-1:0] last_bid, last_ask;
  logic                  bid_live, ask_live;
  logic                  need_ask_r;
  logic [GAP_W-1:0]      gap_cnt;

  logic capture, crossed, need_bid_c, need_ask_c, handshake;

  // Unsigned absolute difference, no wrap, compared against the threshold.
  function automatic logic moved(input logic [DATA_WIDTH-1:0] a,
                                 input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return diff >= DATA_WIDTH'(THRESH);
  endfunction

  assign o_order_qty = QTY_WIDTH'(ORDER_QTY);
  assign o_busy      = (state != IDLE);
  assign handshake   = o_order_valid && i_order_ready;

  // Quote classification and per-side send decision for the pending quote.
  always_comb begin
    capture    = i_data_valid && (i_buy_price < i_ask_price);
    crossed    = i_data_valid && !(i_buy_price < i_ask_price);
    need_bid_c = !bid_live || moved(pend_bid, last_bid);
    need_ask_c = !ask_live || moved(pend_ask, last_ask);
  end

  // Order FSM, pending capture, gap timer and drop counter; all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      pend_valid    <= 1'b0;
      pend_bid      <= '0;
      pend_ask      <= '0;
      work_bid      <= '0;
      work_ask      <= '0;
      last_bid      <= '0;
      last_ask      <= '0;
      bid_live      <= 1'b0;
      ask_live      <= 1'b0;
      need_ask_r    <= 1'b0;
      gap_cnt       <= '0;
      o_order_valid <= 1'b0;
      o_order_side  <= 1'b0;
      o_order_type  <= T_NEW;
      o_order_price <= '0;
      o_drop_count  <= '0;
    end else begin
      if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;

      case (state)
        IDLE: begin
          if (pend_valid && gap_cnt == '0) begin
            work_bid   <= pend_bid;
            work_ask   <= pend_ask;
            pend_valid <= 1'b0;
            need_ask_r <= need_ask_c;
            if (need_bid_c) begin
              state         <= SEND_BID;
              o_order_valid <= 1'b1;
              o_order_side  <= 1'b0;
              o_order_price <= pend_bid;
              o_order_type  <= bid_live ? T_REPLACE : T_NEW;
            end else if (need_ask_c) begin
              state         <= SEND_ASK;
              o_order_valid <= 1'b1;
              o_order_side  <= 1'b1;
              o_order_price <= pend_ask;
              o_order_type  <= ask_live ? T_REPLACE : T_NEW;
            end
          end
        end
        SEND_BID: begin
          if (handshake) begin
            last_bid <= work_bid;
            bid_live <= 1'b1;
            if (need_ask_r) begin
              // valid stays high straight into the ask order
              state         <= SEND_ASK;
              o_order_side  <= 1'b1;
              o_order_price <= work_ask;
              o_order_type  <= ask_live ? T_REPLACE : T_NEW;
            end else begin
              state         <= IDLE;
              o_order_valid <= 1'b0;
              gap_cnt       <= GAP_W'(MIN_GAP);
            end
          end
        end
        SEND_ASK: begin
          if (handshake) begin
            last_ask      <= work_ask;
            ask_live      <= 1'b1;
            state         <= IDLE;
            o_order_valid <= 1'b0;
            gap_cnt       <= GAP_W'(MIN_GAP);
          end
        end
        default: begin
          state         <= IDLE;
          o_order_valid <= 1'b0;
        end
      endcase

      // A fresh quote overrides the IDLE consume above, so the latest always wins.
      if (capture) begin
        pend_bid   <= i_buy_price;
        pend_ask   <= i_ask_price;
        pend_valid <= 1'b1;
      end
      if (crossed && o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 16'd1;
    end
  end

endmodule
